// File: rtl/split_seq.sv
// split_seq: takes one wide word per handshake and streams its
// unit-wide lanes one per cycle, LSB- or MSB-lane first.
module split_seq #(
  parameter int C_IN_WIDTH   = 32,
  parameter int C_UNIT_WIDTH = 8,
  parameter int C_MSB_FIRST  = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [C_IN_WIDTH-1:0]   in_data,
  input  logic [4:0]              in_len,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [C_UNIT_WIDTH-1:0] out_data,
  output logic [3:0]              out_idx,
  output logic                    out_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    busy,
  output logic                    len_err
);

  localparam int C_UNITS = C_IN_WIDTH / C_UNIT_WIDTH;
  localparam logic [4:0] UNITS5 = 5'(C_UNITS);
  localparam logic [3:0] PTR0 =
    (C_MSB_FIRST != 0) ? 4'(C_UNITS - 1) : 4'd0;

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  state_t                  state_q, state_d;
  logic [C_IN_WIDTH-1:0]   hold_q, hold_d;
  logic [4:0]              rem_q, rem_d;
  logic [3:0]              ptr_q, ptr_d;
  logic                    len_err_q, len_err_d;

  logic                    send;
  logic                    fire;
  logic                    accept;
  logic                    load_err;
  logic [4:0]              load_len;
  logic [C_UNIT_WIDTH-1:0] lane;

  always_comb begin
    lane = '0;
    for (int k = 0; k < C_UNITS; k++) begin
      if (ptr_q == k[3:0]) begin
        lane = hold_q[k*C_UNIT_WIDTH +: C_UNIT_WIDTH];
      end
    end
  end

  always_comb begin
    send      = (state_q == SEND);
    out_valid = send;
    busy      = send;
    out_last  = send && (rem_q == 5'd1);
    out_data  = send ? lane : '0;
    out_idx   = send ? ptr_q : 4'd0;
    len_err   = len_err_q;
    fire      = send & out_ready;
    in_ready  = rst_n & (!send | (fire & out_last));
    accept    = in_valid & in_ready;
    // Zero and oversize lengths both mean a full word.
    load_err  = (in_len > UNITS5);
    load_len  = ((in_len == 5'd0) || load_err) ? UNITS5 : in_len;
  end

  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    rem_d     = rem_q;
    ptr_d     = ptr_q;
    len_err_d = 1'b0;
    if (fire) begin
      rem_d = rem_q - 5'd1;
      ptr_d = (C_MSB_FIRST != 0) ? ptr_q - 4'd1 : ptr_q + 4'd1;
      if (out_last) begin
        state_d = IDLE;
      end
    end
    // A word taken on the last-unit handshake reloads directly.
    if (accept) begin
      hold_d    = in_data;
      rem_d     = load_len;
      ptr_d     = PTR0;
      len_err_d = load_err;
      state_d   = SEND;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      hold_q    <= '0;
      rem_q     <= '0;
      ptr_q     <= '0;
      len_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      rem_q     <= rem_d;
      ptr_q     <= ptr_d;
      len_err_q <= len_err_d;
    end
  end

endmodule

// File: tb/tb_split_seq.sv
// tb_split_seq: directed checks of split_seq, one LSB-first
// instance and one MSB-first instance.
module tb_split_seq;

  logic        clk;
  logic        rst_n;
  logic [31:0] in_data;
  logic [4:0]  in_len;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  out_data;
  logic [3:0]  out_idx;
  logic        out_last;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic        len_err;

  logic [31:0] m_in_data;
  logic [4:0]  m_in_len;
  logic        m_in_valid;
  logic        m_in_ready;
  logic [7:0]  m_out_data;
  logic [3:0]  m_out_idx;
  logic        m_out_last;
  logic        m_out_valid;
  logic        m_out_ready;
  logic        m_busy;
  logic        m_len_err;

  int n_tests;
  int n_fail;

  split_seq #(.C_IN_WIDTH(32), .C_UNIT_WIDTH(8), .C_MSB_FIRST(0)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_len(in_len),
    .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
    .out_idx(out_idx), .out_last(out_last), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .len_err(len_err)
  );

  split_seq #(.C_IN_WIDTH(32), .C_UNIT_WIDTH(8), .C_MSB_FIRST(1)) dut_m (
    .clk(clk), .rst_n(rst_n), .in_data(m_in_data), .in_len(m_in_len),
    .in_valid(m_in_valid), .in_ready(m_in_ready),
    .out_data(m_out_data), .out_idx(m_out_idx),
    .out_last(m_out_last), .out_valid(m_out_valid),
    .out_ready(m_out_ready), .busy(m_busy), .len_err(m_len_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic unit(input string tag, input logic [7:0] d,
                      input logic [3:0] idx, input logic last);
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_data"}, 32'(out_data), 32'(d));
    chk({tag, "_idx"}, 32'(out_idx), 32'(idx));
    chk({tag, "_last"}, 32'(out_last), 32'(last));
  endtask

  initial begin
    n_tests     = 0;
    n_fail      = 0;
    rst_n       = 1'b0;
    in_data     = '0;
    in_len      = '0;
    in_valid    = 1'b0;
    out_ready   = 1'b1;
    m_in_data   = '0;
    m_in_len    = '0;
    m_in_valid  = 1'b0;
    m_out_ready = 1'b1;

    // Reset state
    step();
    step();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_last", 32'(out_last), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_idx", 32'(out_idx), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_lenerr", 32'(len_err), 32'd0);
    chk("rst_inrdy", 32'(in_ready), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("idle_inrdy", 32'(in_ready), 32'd1);

    // 1: full word, LSB first
    in_data  = 32'hDDCCBBAA;
    in_len   = 5'd0;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    in_data  = 32'h0;
    unit("t1_c1", 8'hAA, 4'd0, 1'b0);
    chk("t1_c1_busy", 32'(busy), 32'd1);
    chk("t1_c1_inrdy", 32'(in_ready), 32'd0);
    step();
    unit("t1_c2", 8'hBB, 4'd1, 1'b0);
    chk("t1_c2_inrdy", 32'(in_ready), 32'd0);
    step();
    unit("t1_c3", 8'hCC, 4'd2, 1'b0);
    chk("t1_c3_inrdy", 32'(in_ready), 32'd0);
    step();
    unit("t1_c4", 8'hDD, 4'd3, 1'b1);
    chk("t1_c4_busy", 32'(busy), 32'd1);
    step();
    chk("t1_end_valid", 32'(out_valid), 32'd0);
    chk("t1_end_busy", 32'(busy), 32'd0);

    // 2: MSB-first instance, partial word of 2
    m_in_data  = 32'hDDCCBBAA;
    m_in_len   = 5'd2;
    m_in_valid = 1'b1;
    #1;
    chk("t2_inrdy", 32'(m_in_ready), 32'd1);
    step();
    m_in_valid = 1'b0;
    chk("t2_c1_valid", 32'(m_out_valid), 32'd1);
    chk("t2_c1_data", 32'(m_out_data), 32'hDD);
    chk("t2_c1_idx", 32'(m_out_idx), 32'd3);
    chk("t2_c1_last", 32'(m_out_last), 32'd0);
    step();
    chk("t2_c2_data", 32'(m_out_data), 32'hCC);
    chk("t2_c2_idx", 32'(m_out_idx), 32'd2);
    chk("t2_c2_last", 32'(m_out_last), 32'd1);
    step();
    chk("t2_end_valid", 32'(m_out_valid), 32'd0);
    chk("t2_end_busy", 32'(m_busy), 32'd0);

    // 3: back-to-back words, gap-free
    in_data  = 32'h11223344;
    in_len   = 5'd0;
    in_valid = 1'b1;
    step();
    in_data = 32'h55667788;
    unit("t3_u0", 8'h44, 4'd0, 1'b0);
    step();
    unit("t3_u1", 8'h33, 4'd1, 1'b0);
    chk("t3_u1_inrdy", 32'(in_ready), 32'd0);
    step();
    unit("t3_u2", 8'h22, 4'd2, 1'b0);
    step();
    unit("t3_u3", 8'h11, 4'd3, 1'b1);
    chk("t3_u3_inrdy", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    unit("t3_u4", 8'h88, 4'd0, 1'b0);
    step();
    unit("t3_u5", 8'h77, 4'd1, 1'b0);
    step();
    unit("t3_u6", 8'h66, 4'd2, 1'b0);
    step();
    unit("t3_u7", 8'h55, 4'd3, 1'b1);
    step();
    chk("t3_end_valid", 32'(out_valid), 32'd0);

    // 4: backpressure after BB
    in_data  = 32'hDDCCBBAA;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    unit("t4_u0", 8'hAA, 4'd0, 1'b0);
    step();
    unit("t4_u1", 8'hBB, 4'd1, 1'b0);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      unit("t4_hold", 8'hBB, 4'd1, 1'b0);
      chk("t4_hold_inrdy", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    step();
    unit("t4_u2", 8'hCC, 4'd2, 1'b0);
    step();
    unit("t4_u3", 8'hDD, 4'd3, 1'b1);
    step();
    chk("t4_end_valid", 32'(out_valid), 32'd0);

    // 5: oversize length is clamped and flagged
    in_data  = 32'h44332211;
    in_len   = 5'd9;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    in_len   = 5'd0;
    chk("t5_lenerr_on", 32'(len_err), 32'd1);
    unit("t5_u0", 8'h11, 4'd0, 1'b0);
    step();
    chk("t5_lenerr_off", 32'(len_err), 32'd0);
    unit("t5_u1", 8'h22, 4'd1, 1'b0);
    step();
    unit("t5_u2", 8'h33, 4'd2, 1'b0);
    step();
    unit("t5_u3", 8'h44, 4'd3, 1'b1);
    step();
    chk("t5_end_valid", 32'(out_valid), 32'd0);
    chk("t5_end_lenerr", 32'(len_err), 32'd0);

    // 6: reset mid-word discards the word
    in_data  = 32'hDDCCBBAA;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    unit("t6_u0", 8'hAA, 4'd0, 1'b0);
    step();
    unit("t6_u1", 8'hBB, 4'd1, 1'b0);
    rst_n = 1'b0;
    step();
    chk("t6_rst_valid", 32'(out_valid), 32'd0);
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_inrdy", 32'(in_ready), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("t6_post_inrdy", 32'(in_ready), 32'd1);
    step();
    chk("t6_idle_valid", 32'(out_valid), 32'd0);
    in_data  = 32'h04030201;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    unit("t6_new_u0", 8'h01, 4'd0, 1'b0);
    step();
    unit("t6_new_u1", 8'h02, 4'd1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/split_seq.md
Name: split_seq

Overview:
- Sequencer for the word-splitting datapath.
- Accepts one wide word (C_IN_WIDTH bits) per valid/ready handshake and emits its C_UNIT_WIDTH-bit units one per cycle on a unit stream, with index and last flag.
- Sits between a wide producer and a narrow consumer that cannot take all lanes in parallel.
- Supports partial words through a per-word unit count, and LSB-first or MSB-first lane order.

Parameters:
- C_IN_WIDTH, 32, input word width; must be an integer multiple of C_UNIT_WIDTH.
- C_UNIT_WIDTH, 8, width of one emitted unit.
- C_MSB_FIRST, 0, 0 = emit lane 0 (bits [C_UNIT_WIDTH-1:0]) first; 1 = emit highest lane first.
- Derived, not overridable: C_UNITS = C_IN_WIDTH/C_UNIT_WIDTH, legal range 1..16.

Ports:
- clk, input, 1, sole clock, all logic on rising edge.
- rst_n, input, 1, synchronous active-low reset.
- in_data, input, C_IN_WIDTH, word to split.
- in_len, input, 5, number of units to emit: 1..16; 0 means C_UNITS.
- in_valid, input, 1, word offered.
- in_ready, output, 1, word accepted when in_valid & in_ready.
- out_data, output, C_UNIT_WIDTH, current unit.
- out_idx, output, 4, lane number of current unit within the word.
- out_last, output, 1, current unit is the final one of the word.
- out_valid, output, 1, unit valid.
- out_ready, input, 1, consumer accepts unit.
- busy, output, 1, a word is held (state SEND).
- len_err, output, 1, one-cycle pulse: accepted word had in_len > C_UNITS.

Behaviour:
- Reset (rst_n=0 at a clock edge): state IDLE; out_valid=0, out_last=0, out_data=0, out_idx=0, busy=0, len_err=0. in_ready is combinational and is 0 during reset. Reset mid-word discards the held word with no further units.
- States:
  - IDLE: in_ready=1. On handshake, capture in_data into a holding register and set remaining count N (0→C_UNITS; >C_UNITS→C_UNITS with len_err=1 next cycle). Set lane pointer to 0 (LSB-first) or C_UNITS-1 (MSB-first). Go to SEND.
  - SEND: out_valid=1, out_data = held lane at pointer, out_idx = pointer, out_last = (remaining==1).
    - On out_valid & out_ready: decrement remaining; pointer +1 (LSB-first) or −1 (MSB-first).
    - If out_last was set at that handshake: go to IDLE, unless a new word is accepted in the same cycle.
- Latency: first unit appears on out_* the cycle after the input handshake. No combinational path from in_* to out_*.
- Back-to-back: in_ready = IDLE | (SEND & out_valid & out_ready & out_last). A word accepted on the last-unit handshake loads directly and stays in SEND, so units are gap-free. Sustained throughput is N units per N cycles.
- Backpressure: with out_ready=0, out_data/out_idx/out_last/out_valid hold stable. in_ready stays 0 during SEND except on the last-unit handshake.
- in_data is sampled only at the handshake. Changes afterwards have no effect.
- Partial word, LSB-first: lanes 0..N-1 are emitted. MSB-first: lanes C_UNITS-1 down to C_UNITS-N.
- Pointer never wraps within a word; remaining reaches 0 exactly at out_last.
- C_UNITS=1: every word is a single unit with out_last=1, out_idx=0.
- len_err does not block the transfer; the clamped word is emitted normally.
- Unit lanes map exactly as in_data[C_UNIT_WIDTH*k +: C_UNIT_WIDTH] for lane k.

Test Plan:
1. Reset, defaults, in_data=32'hDDCCBBAA, in_len=0, out_ready=1 → cycles 1-4: out_data AA,BB,CC,DD; out_idx 0,1,2,3; out_last only on DD; busy 1 for 4 cycles; in_ready 0 during cycles 1-3.
2. C_MSB_FIRST=1, same word, in_len=2 → out_data DD,CC; out_idx 3,2; out_last on CC; then IDLE.
3. Two words offered back-to-back (11223344 then 55667788, in_len=0) with out_ready=1 → 8 consecutive valid cycles 44,33,22,11,88,77,66,55. Second word accepted on the cycle 11 is handshaken.
4. out_ready held low 3 cycles mid-word after BB → out_data=BB, out_idx=1 held stable; in_ready=0; sequence resumes with CC, no loss or duplicate.
5. in_len=9 with C_UNITS=4 → len_err pulses one cycle after accept; exactly 4 units emitted; out_last on lane 3.
6. rst_n=0 for one cycle after the second unit of a word → out_valid=0 next cycle; no further units; in_ready=1 once rst_n=1; a new word then emits from lane 0.
